en_bank_scheduler: RTL

//  Write scheduler for a bank of N per-bit enabled flops (shared serial data line, one enable per bit).

---
 rtl/en_bank_sched_pkg.sv | 27 ++
 rtl/en_bank_scheduler_rr_pick.sv | 38 +++
 rtl/en_bank_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/en_bank_sched_pkg.sv
// Shared types and helpers for the en_bank_scheduler write scheduler.
// The optional per-bit activity counters are enabled with ACTIVITY_CNT_EN.
package en_bank_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned DEF_CNT_SAT = (1 << DEF_CNT_W) - 1;

    // Bits needed to index n items; at least 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned v;
        int unsigned w;
        v = (n > 1) ? n - 1 : 1;
        w = 0;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/en_bank_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible bit at or after ptr, wrapping N-1 -> 0.
module rr_pick
    import en_bank_sched_pkg::*;
#(
    parameter int N  = 5,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] pos;
        // NOTE: every output gets a default before the search, so no path leaves a latch.
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        pos     = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            pos = sum[IW-1:0];
            if (!any && elig[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/en_bank_scheduler.sv
// Round-robin write scheduler plus one-bit-per-cycle sweep for a bank of per-bit enabled flops.
// Define ACTIVITY_CNT_EN to add the saturating per-bit ACT_CNT write counters.
module en_bank_scheduler
    import en_bank_sched_pkg::*;
#(
    parameter int N = 5
`ifdef ACTIVITY_CNT_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] REQ,
    input  logic [N-1:0] REQ_DATA,
    output logic [N-1:0] ACK,
    input  logic         SWEEP_START,
    input  logic         SWEEP_DATA,
    output logic         SWEEP_BUSY,
    output logic         SWEEP_DONE,
    output logic [N-1:0] EN,
    output logic         D_OUT
`ifdef ACTIVITY_CNT_EN
    ,
    output logic [N*CNT_W-1:0] ACT_CNT
`endif
);

    localparam int IW = clog2(N);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic          sdata_q, sdata_d;
    logic [N-1:0]  en_q,    en_d;
    logic [N-1:0]  ack_q,   ack_d;
    logic          dout_q,  dout_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic [N-1:0]  elig;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    // The bit acked this cycle is still shown on REQ; masking it prevents a double grant.
    assign elig = REQ & ~ack_q;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .elig    (elig),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        sdata_d = sdata_q;
        en_d    = '0;
        ack_d   = '0;
        dout_d  = dout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // busy_q is still high in the DRAIN output cycle, so a start there is dropped.
                if (SWEEP_START && !busy_q) begin
                    sdata_d = SWEEP_DATA;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SWEEP;
                end else if (pick_any) begin
                    en_d   = pick_gnt;
                    ack_d  = pick_gnt;
                    dout_d = REQ_DATA[pick_idx];
                    ptr_d  = (pick_idx == IW'(N-1)) ? '0 : pick_idx + IW'(1);
                end
            end
            SWEEP: begin
                busy_d = 1'b1;
                en_d   = N'(1) << idx_q;
                dout_d = sdata_q;
                if (idx_q == IW'(N-1)) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DRAIN: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            sdata_q <= 1'b0;
            en_q    <= '0;
            ack_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            sdata_q <= sdata_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign EN         = en_q;
    assign ACK        = ack_q;
    assign D_OUT      = dout_q;
    assign SWEEP_BUSY = busy_q;
    assign SWEEP_DONE = done_q;

`ifdef ACTIVITY_CNT_EN
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en_q[i] && (cnt_q[i] != CNT_SAT)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: these counters are architectural state cleared only by RST, so the array is reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_act
        assign ACT_CNT[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule
